ct_ifu_sram_seq_512x22: RTL and testbench
=========================================

# ct_ifu_sram_seq_512x22

Access sequencer sitting directly upstream of the IFU 512x22 single-port SRAM macro wrapper.
- After reset, and on demand, sweeps the whole array to a known value (invalidate).
- Otherwise arbitrates one write and one read client onto the single port, driving the macro's active-low CEN/GWEN/WEN pins.
- Qualifies the macro's 1-cycle-latency Q output with a valid strobe.

## Interface
Parameters:
- ADDR_WIDTH, 9, SRAM address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 22, SRAM word and bit-mask width
- INIT_VALUE, 22'h0, word written on every sweep

Ports (one clock; reset is asynchronous and active-low):
- forever_cpuclk  in  1  clock, also drives the SRAM CLK
- cpurst_b  in  1  asynchronous active-low reset
- inv_all_req  in  1  level/pulse: request full-array invalidate sweep
- inv_all_done  out  1  one-cycle pulse at end of each sweep
- busy  out  1  high whenever state is not READY
- wr_req  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_mask  in  DATA_WIDTH  active-high bit enables
- wr_gnt  out  1  write accepted this cycle
- rd_req  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_gnt  out  1  read accepted this cycle
- rd_vld  out  1  rd_data valid (cycle after rd_gnt)
- rd_data  out  DATA_WIDTH  read data, = sram_q
- sram_a  out  ADDR_WIDTH  to macro A
- sram_cen  out  1  to macro CEN, active-low
- sram_gwen  out  1  to macro GWEN, active-low
- sram_wen  out  DATA_WIDTH  to macro WEN, active-low per bit
- sram_d  out  DATA_WIDTH  to macro D
- sram_q  in  DATA_WIDTH  from macro Q

## Operation
- States:
  - RESET: entered asynchronously while cpurst_b=0; lasts 1 cycle after deassert.
  - SWEEP: 9-bit counter cnt, 0..2^ADDR_WIDTH-1.
  - READY.
- Transitions:
  - RESET -> SWEEP with cnt=0.
  - SWEEP at cnt=max -> READY, or back to SWEEP with cnt=0 if inv_pend=1 (inv_pend is then cleared).
  - READY with inv_all_req=1 -> SWEEP with cnt=0.
- SWEEP cycle outputs: sram_cen=0, sram_gwen=0, sram_wen=all-0, sram_a=cnt, sram_d=INIT_VALUE. cnt increments by 1 and wraps to 0 on exit.
- inv_all_done pulses in the cycle after the cnt=max write, for both post-reset and requested sweeps.
- inv_all_req seen during SWEEP sets inv_pend; multiple requests collapse into one extra sweep. It is ignored during RESET.
- READY priority: inv_all_req > write > read.
  - Cycle with inv_all_req: no grants, SRAM idle.
  - Write granted: sram_cen=0, sram_gwen=0, sram_wen=~wr_mask, sram_a=wr_addr, sram_d=wr_data.
  - Read granted: sram_cen=0, sram_gwen=1, sram_wen=all-1, sram_a=rd_addr.
  - Nothing granted: sram_cen=1, sram_gwen=1, sram_wen=all-1; sram_a and sram_d hold their last values.
- wr_gnt and rd_gnt are 0 outside READY. A requester holds its request until granted (req/gnt handshake, no buffering).
- rd_vld is a flop equal to the previous cycle's rd_gnt. rd_data=sram_q and is meaningful only when rd_vld=1.
- Read-after-write to the same address in consecutive cycles returns the new data. A read granted in the cycle before a write returns the old data.

## Timing
- Reset values:
  - State RESET, cnt=0, inv_pend=0.
  - rd_vld=0, inv_all_done=0, busy=1, wr_gnt=0, rd_gnt=0.
  - sram_cen=1, sram_gwen=1, sram_wen=all-1, sram_a=0, sram_d=0.
- SRAM control outputs and grants are combinational from the current state, cnt, and requests, so the macro samples them at the next edge.
- Read latency is 1 cycle (grant at cycle N, rd_vld at N+1). Write is complete at the grant edge.
- Post-reset sweep:
  - Cycle 0 after cpurst_b rises: RESET.
  - Cycles 1..512: sweep writes.
  - Cycle 513: inv_all_done=1, busy=0, first grant possible.
- Reset asserted mid-sweep or mid-read: immediate return to RESET, rd_vld drops asynchronously to 0, full sweep restarts after deassert.

## Structure
- Package ct_ifu_sram_seq_pkg: state enum (RESET, SWEEP, READY), ADDR_WIDTH/DATA_WIDTH defaults, INIT_VALUE default.
- One sub-module, ct_ifu_sram_sweep_cnt: holds cnt and inv_pend; outputs cnt, last (cnt=max), and pend.
- The top module owns the state machine, arbitration mux, and rd_vld flop. The SRAM macro is instantiated by the parent, not inside this block.

## Test plan
- Reset release, no requests -> 1 RESET cycle, then 512 writes with sram_a 0..511, sram_wen=0, sram_d=0. inv_all_done pulses once at cycle 513, where busy falls. No grants before 513.
- Write 0x2AAAAA mask 0x3FFFFF at addr 5, then read addr 5 -> wr_gnt same cycle. Read gets rd_gnt next cycle and rd_vld one cycle later with rd_data=0x2AAAAA.
- Write 0x3FFFFF mask 0x00000F to addr 5 after the previous write, then read -> rd_data=0x2AAAAF.
- wr_req and rd_req together at addr 7 -> wr_gnt=1 and rd_gnt=0 that cycle. Next cycle rd_gnt=1, and rd_data returns the written value.
- inv_all_req at sweep cnt=100 -> sweep finishes, a second sweep starts immediately with cnt=0 and no READY cycle. Two inv_all_done pulses, 1024 write cycles total.
- cpurst_b low for 2 cycles at sweep cnt=300 -> sram_cen=1 during reset, then RESET and a full 512-entry sweep from addr 0.

Source files
------------

// File: rtl/ct_ifu_sram_seq_pkg.sv
// rtl/ct_ifu_sram_seq_pkg.sv - shared types and defaults for the IFU 512x22 SRAM sequencer
package ct_ifu_sram_seq_pkg;

    localparam int              ADDR_WIDTH_DEF = 9;
    localparam int              DATA_WIDTH_DEF = 22;
    localparam logic [21:0]     INIT_VALUE_DEF = 22'h0;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_SWEEP = 2'd1,
        ST_READY = 2'd2
    } seq_state_e;

endpackage

// File: rtl/ct_ifu_sram_sweep_cnt.sv
// rtl/ct_ifu_sram_sweep_cnt.sv - sweep address counter and pending-invalidate flag
module ct_ifu_sram_sweep_cnt
    import ct_ifu_sram_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sweep_en,
    input  logic                  inv_req,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic                  last,
    output logic                  pend
);

    assign last = &cnt;

    // cnt advances on every sweep cycle and wraps to 0 on the final one, so a
    // new sweep always starts from address 0; requests seen mid-sweep collapse
    // into a single pending flag that is consumed at the last address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else if (sweep_en) begin
            cnt <= cnt + 1'b1;
            if (last) begin
                pend <= 1'b0;
            end else if (inv_req) begin
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ct_ifu_sram_seq_512x22.sv
// rtl/ct_ifu_sram_seq_512x22.sv - invalidate sweep and write/read arbitration for the IFU 512x22 SRAM
module ct_ifu_sram_seq_512x22
    import ct_ifu_sram_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(INIT_VALUE_DEF)
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  inv_all_req,
    output logic                  inv_all_done,
    output logic                  busy,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    seq_state_e            state_q;
    seq_state_e            state_d;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  cnt_last;
    logic                  inv_pend;
    logic                  sweep_en;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  done_q;
    logic                  rd_vld_q;

    assign sweep_en     = (state_q == ST_SWEEP);
    assign busy         = (state_q != ST_READY);
    assign inv_all_done = done_q;
    assign rd_vld       = rd_vld_q;
    assign rd_data      = sram_q;

    ct_ifu_sram_sweep_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sweep_cnt (
        .clk      (forever_cpuclk),
        .rst_n    (cpurst_b),
        .sweep_en (sweep_en),
        .inv_req  (inv_all_req),
        .cnt      (cnt),
        .last     (cnt_last),
        .pend     (inv_pend)
    );

    // state register plus the registered side outputs: done pulse, read valid,
    // and the last driven address/data so an idle macro sees stable pins
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q  <= ST_RESET;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            a_q      <= '0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= sweep_en && cnt_last;
            rd_vld_q <= rd_gnt;
            a_q      <= sram_a;
            d_q      <= sram_d;
        end
    end

    // next state, grants and macro pins; a request arriving on the very last
    // sweep address is honoured like a pending one so it is never dropped
    always_comb begin
        state_d   = state_q;
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_q;
        sram_d    = d_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_SWEEP;
            end
            ST_SWEEP: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = cnt;
                sram_d    = INIT_VALUE;
                if (cnt_last) begin
                    state_d = (inv_pend || inv_all_req) ? ST_SWEEP : ST_READY;
                end
            end
            ST_READY: begin
                if (inv_all_req) begin
                    state_d = ST_SWEEP;
                end else if (wr_req) begin
                    wr_gnt    = 1'b1;
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = ~wr_mask;
                    sram_a    = wr_addr;
                    sram_d    = wr_data;
                end else if (rd_req) begin
                    rd_gnt    = 1'b1;
                    sram_cen  = 1'b0;
                    sram_a    = rd_addr;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_ct_ifu_sram_seq_512x22.sv
// tb/tb_ct_ifu_sram_seq_512x22.sv - self-checking bench for ct_ifu_sram_seq_512x22
module tb_ct_ifu_sram_seq_512x22;

    localparam int          AW    = 9;
    localparam int          DW    = 22;
    localparam int          DEPTH = 512;
    localparam logic [21:0] INIT  = 22'h0;

    logic          forever_cpuclk;
    logic          cpurst_b;
    logic          inv_all_req;
    logic          inv_all_done;
    logic          busy;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_mask;
    logic          wr_gnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];

    int total;
    int bad;

    ct_ifu_sram_seq_512x22 dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .inv_all_req    (inv_all_req),
        .inv_all_done   (inv_all_done),
        .busy           (busy),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_mask        (wr_mask),
        .wr_gnt         (wr_gnt),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_vld         (rd_vld),
        .rd_data        (rd_data),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // behavioural single-port macro: bit-masked write, 1-cycle read
    always @(posedge forever_cpuclk) begin
        if (sram_cen === 1'b0) begin
            if (sram_gwen === 1'b0) begin
                for (int b = 0; b < DW; b++) begin
                    if (sram_wen[b] === 1'b0) mem[sram_a][b] <= sram_d[b];
                end
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // caller is in the drive window of the first sweep cycle
    task automatic run_sweeps(input int nsw, input int req_at, input bit exp_wr);
        int pat_bad  = -1;
        int done_bad = -1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
        for (int i = 0; i < nsw * DEPTH; i++) begin
            inv_all_req = (i == req_at);
            @(negedge forever_cpuclk);
            if (pat_bad < 0 && !(sram_cen === 1'b0 && sram_gwen === 1'b0 && sram_wen === '0 &&
                                 sram_a === AW'(i % DEPTH) && sram_d === INIT && busy === 1'b1 &&
                                 wr_gnt === 1'b0 && rd_gnt === 1'b0))
                pat_bad = i;
            if (done_bad < 0 && inv_all_done !== (i > 0 && (i % DEPTH) == 0))
                done_bad = i;
            @(posedge forever_cpuclk);
            #1;
        end
        inv_all_req = 1'b0;
        chk("sweep_pattern_first_bad_cycle", pat_bad, -1);
        chk("sweep_done_first_bad_cycle", done_bad, -1);
        @(negedge forever_cpuclk);
        chk("sweep_end_done", inv_all_done, 1'b1);
        chk("sweep_end_busy", busy, 1'b0);
        chk("sweep_end_wr_gnt", wr_gnt, exp_wr);
        if (exp_wr) model_mem[wr_addr] = (model_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        @(posedge forever_cpuclk);
        #1;
        rd_req  = 1'b0;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mask = m;
        @(negedge forever_cpuclk);
        chk("wr_gnt_same_cycle", wr_gnt, 1'b1);
        chk("wr_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {1'b0, 1'b0, ~m, a, d});
        model_mem[a] = (model_mem[a] & ~m) | (d & m);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] got);
        logic [DW-1:0] exp;
        @(posedge forever_cpuclk);
        #1;
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge forever_cpuclk);
        chk("rd_gnt", rd_gnt, 1'b1);
        chk("rd_pins", {sram_cen, sram_gwen, sram_wen, sram_a}, {1'b0, 1'b1, {DW{1'b1}}, a});
        exp = model_mem[a];
        @(posedge forever_cpuclk);
        #1;
        rd_req = 1'b0;
        @(negedge forever_cpuclk);
        chk("rd_vld", rd_vld, 1'b1);
        chk("rd_data", rd_data, exp);
        chk("idle_hold", {sram_cen, sram_gwen, sram_a}, {1'b1, 1'b1, a});
        got = rd_data;
    endtask

    initial begin
        logic [DW-1:0] got;
        logic [AW-1:0] ra;
        total       = 0;
        bad         = 0;
        cpurst_b    = 1'b0;
        inv_all_req = 1'b0;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_mask     = '0;
        rd_req      = 1'b0;
        rd_addr     = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;

        repeat (2) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        chk("reset_flags", {rd_vld, inv_all_done, busy, wr_gnt, rd_gnt}, 5'b00100);
        chk("reset_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
            {1'b1, 1'b1, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}});

        // release with both clients already requesting; nothing may be granted until READY
        @(posedge forever_cpuclk);
        #1;
        cpurst_b = 1'b1;
        wr_req   = 1'b1;
        wr_addr  = 9'd3;
        wr_data  = 22'($urandom);
        wr_mask  = 22'h3FFFFF;
        rd_req   = 1'b1;
        rd_addr  = 9'd3;
        @(negedge forever_cpuclk);
        chk("reset_cycle_idle", {busy, sram_cen, wr_gnt, rd_gnt}, 4'b1100);
        @(posedge forever_cpuclk);
        #1;
        run_sweeps(1, -1, 1'b1);
        do_read(9'd3, got);

        do_write(9'd5, 22'h2AAAAA, 22'h3FFFFF);
        do_read(9'd5, got);
        chk("raw_full_mask", got, 22'h2AAAAA);
        do_write(9'd5, 22'h3FFFFF, 22'h00000F);
        do_read(9'd5, got);
        chk("raw_partial_mask", got, 22'h2AAAAF);

        // write beats read in the same cycle; read follows next cycle
        @(posedge forever_cpuclk);
        #1;
        wr_req  = 1'b1;
        wr_addr = 9'd7;
        wr_data = 22'h15A5A5;
        wr_mask = 22'h3FFFFF;
        rd_req  = 1'b1;
        rd_addr = 9'd7;
        @(negedge forever_cpuclk);
        chk("both_req_gnts", {wr_gnt, rd_gnt}, 2'b10);
        model_mem[7] = 22'h15A5A5;
        @(posedge forever_cpuclk);
        #1;
        wr_req = 1'b0;
        @(negedge forever_cpuclk);
        chk("both_req_rd_next", rd_gnt, 1'b1);
        @(posedge forever_cpuclk);
        #1;
        rd_req = 1'b0;
        @(negedge forever_cpuclk);
        chk("both_req_rd_data", {rd_vld, rd_data}, {1'b1, 22'h15A5A5});

        for (int n = 0; n < 40; n++) begin
            ra = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) do_write(ra, 22'($urandom), 22'($urandom));
            else do_read(ra, got);
        end

        // invalidate from READY, then a request at cnt=100 chains a second sweep
        @(posedge forever_cpuclk);
        #1;
        inv_all_req = 1'b1;
        wr_req      = 1'b1;
        wr_addr     = 9'd9;
        rd_req      = 1'b0;
        @(negedge forever_cpuclk);
        chk("inv_cycle_idle", {wr_gnt, rd_gnt, sram_cen, busy}, 4'b0010);
        @(posedge forever_cpuclk);
        #1;
        wr_req = 1'b0;
        run_sweeps(2, 100, 1'b0);
        do_read(9'd5, got);
        chk("post_inv_read", got, INIT);

        // reset in the middle of a read drops rd_vld asynchronously
        @(posedge forever_cpuclk);
        #1;
        rd_req  = 1'b1;
        rd_addr = 9'd5;
        @(negedge forever_cpuclk);
        chk("mid_read_gnt", rd_gnt, 1'b1);
        @(posedge forever_cpuclk);
        #1;
        rd_req = 1'b0;
        chk("mid_read_vld_before", rd_vld, 1'b1);
        cpurst_b = 1'b0;
        #1;
        chk("mid_read_vld_async", {rd_vld, busy, sram_cen}, 3'b011);
        @(posedge forever_cpuclk);
        #1;
        cpurst_b = 1'b1;
        @(negedge forever_cpuclk);
        chk("mid_read_reset_cycle", {busy, sram_cen}, 2'b11);
        @(posedge forever_cpuclk);
        #1;
        run_sweeps(1, -1, 1'b0);

        // reset for two cycles at sweep cnt=300 restarts a full sweep
        @(posedge forever_cpuclk);
        #1;
        inv_all_req = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        inv_all_req = 1'b0;
        repeat (300) begin
            @(posedge forever_cpuclk);
            #1;
        end
        chk("mid_sweep_addr_300", {sram_cen, sram_a}, {1'b0, 9'd300});
        cpurst_b = 1'b0;
        #1;
        chk("mid_sweep_reset_idle", {sram_cen, sram_a, busy}, {1'b1, 9'd0, 1'b1});
        repeat (2) @(posedge forever_cpuclk);
        #1;
        chk("mid_sweep_still_idle", sram_cen, 1'b1);
        cpurst_b = 1'b1;
        @(negedge forever_cpuclk);
        chk("mid_sweep_reset_cycle", {busy, sram_cen}, 2'b11);
        @(posedge forever_cpuclk);
        #1;
        run_sweeps(1, -1, 1'b0);

        do_write(9'd300, 22'h123456, 22'h3FFFFF);
        do_read(9'd300, got);
        @(negedge forever_cpuclk);
        chk("final_done_low", inv_all_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
